fifo_queue: RTL and testbench
=============================

Name: fifo_queue

Overview:
- 8-bit first-in/first-out queue for the LEG datapath. It is the other-end counterpart of the existing LIFO stack: pushes enter at the tail and pops leave from the head.
- Uses the same PUSH/POP/VALUE/OUTPUT port style as the stack, so the LEG decoder can route queue opcodes to it exactly as it routes stack opcodes.
- Adds FULL, EMPTY and COUNT status outputs and a sticky error flag.

Parameters:
- DEPTH, 16, number of entries; must be a power of two, minimum 2.
- WIDTH, 8, data width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (clk/rst names as in the rest of the codebase).
- PUSH  input  1  enqueue VALUE on this clock edge.
- POP  input  1  dequeue the head entry on this clock edge.
- VALUE  input  WIDTH  data to enqueue.
- OUTPUT  output  WIDTH  head entry while POP is high and the queue is not empty; otherwise 0.
- FULL  output  1  count == DEPTH.
- EMPTY  output  1  count == 0.
- COUNT  output  log2(DEPTH)+1  number of valid entries.
- ERR  output  1  sticky flag: a push was rejected (overflow) or a pop was rejected (underflow).

Behaviour:
- Reset: rst low asynchronously forces the following, with no clock required:
  - head = 0, tail = 0, count = 0, ERR = 0;
  - all storage cleared to 0;
  - therefore OUTPUT = 0, EMPTY = 1, FULL = 0, COUNT = 0.
- Reset release: rst is released synchronously to clk. The first edge with rst high is a normal cycle.
- State: head and tail pointers of log2(DEPTH) bits, plus a count register. Pointers wrap modulo DEPTH by natural overflow.
- pop_ok = POP & ~EMPTY.
- push_ok = PUSH & (~FULL | pop_ok).
- OUTPUT is combinational: pop_ok ? mem[head] : 0. The zero idle value matches the stack's switched output, so OUTPUT can be ORed onto the shared result bus.
- On the clock edge:
  - push_ok: mem[tail] <= VALUE; tail <= tail+1.
  - pop_ok: head <= head+1.
  - count <= count + push_ok - pop_ok.
- Latency: a pushed value can appear at OUTPUT no earlier than the cycle after the push edge. There is no fall-through: push and pop on an empty queue accepts the push only, and OUTPUT = 0 that cycle.
- Simultaneous push and pop when full: both are accepted.
  - OUTPUT shows the old head during the cycle.
  - The write lands at tail (== head) at the edge.
  - count stays at DEPTH.
- Simultaneous push and pop when 0 < count < DEPTH: both are accepted; count is unchanged.
- Overflow: PUSH while FULL without pop_ok.
  - Push is dropped; storage and pointers are unchanged.
  - ERR <= 1.
- Underflow: POP while EMPTY.
  - No state change; OUTPUT = 0.
  - ERR <= 1.
- ERR clears only on reset.
- Reset asserted mid-operation discards all contents immediately, including any same-cycle push.
- FULL, EMPTY and COUNT are registered-state derived, with no combinational path from PUSH or POP. OUTPUT does combinationally depend on POP.

Decomposition:
- Shared LEG package holds:
  - QUEUE_DEPTH = 16, DATA_W = 8;
  - the pointer-width function clog2;
  - the idle-bus constant BUS_IDLE = 0, also used by the stack.
- One sub-module: fifo_queue_mem, a DEPTH x WIDTH register file.
  - Ports: write enable, write address, write data, async-read address, read data.
  - Async reset clears it to 0.
- Pointer, count and flag logic stays in fifo_queue.

Test Plan:
1. Reset then idle: rst low for 2 cycles, then release. Required: OUTPUT=0, EMPTY=1, FULL=0, COUNT=0, ERR=0. With POP low, OUTPUT stays 0 while entries are present.
2. Order: push 0x11, 0x22, 0x33 on three edges, then pop three times. Required: OUTPUT 0x11, 0x22, 0x33 in order; COUNT 3→0; EMPTY=1 at the end.
3. Full/overflow: push 0x00..0x0F (16 values), then push 0xAA. Required:
   - FULL=1, COUNT=16, ERR=1;
   - 16 pops return 0x00..0x0F;
   - 0xAA is never output.
4. Underflow and push+pop on empty: pop when empty, then push 0x5A with pop high.
   - Required: OUTPUT=0 both cycles; ERR=1; COUNT=1 afterwards.
   - Next pop returns 0x5A.
5. Wrap and full push+pop: fill 16 entries, pop 10, push 10 more (tail wraps).
   - At FULL, push 0x77 with pop high. Required: OUTPUT = oldest entry; COUNT stays 16.
   - Drain and check FIFO order ending with 0x77.
6. Async reset mid-operation: with 5 entries, drop rst between clock edges. Required: EMPTY=1, COUNT=0, ERR=0 immediately, before the next edge. After release, a pop returns OUTPUT=0.

Source files
------------

// File: rtl/fifo_queue_pkg.sv
// Shared LEG datapath definitions used by the queue and the stack.
// Holds default sizes, the pointer-width helper and the idle result-bus value.
package fifo_queue_pkg;

  localparam int QUEUE_DEPTH = 16;
  localparam int DATA_W      = 8;
  localparam int BUS_IDLE    = 0;

  // Smallest w with 2**w >= n; evaluated at elaboration time.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_queue_mem.sv
// DEPTH x WIDTH register file for the queue: one synchronous write port,
// one asynchronous read port, cleared to zero by the asynchronous reset.
module fifo_queue_mem
  import fifo_queue_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH,
  parameter int WIDTH = DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [clog2(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [clog2(DEPTH)-1:0]   rd_addr,
  output logic [WIDTH-1:0]          rd_data
);

  localparam int ADDR_W = clog2(DEPTH);

  logic [WIDTH-1:0] mem_word [DEPTH];

  // Entries are discrete registers because reset must clear every word.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        entry_reg <= '0;
      end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
        entry_reg <= wr_data;
      end
    end

    assign mem_word[gi] = entry_reg;
  end

  assign rd_data = mem_word[rd_addr];

endmodule

// File: rtl/fifo_queue.sv
// FIFO queue for the LEG datapath: push at the tail, pop from the head,
// with FULL/EMPTY/COUNT status, a sticky ERR flag and a zero-idle OUTPUT.
module fifo_queue
  import fifo_queue_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH,
  parameter int WIDTH = DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    PUSH,
  input  logic                    POP,
  input  logic [WIDTH-1:0]        VALUE,
  output logic [WIDTH-1:0]        OUTPUT,
  output logic                    FULL,
  output logic                    EMPTY,
  output logic [clog2(DEPTH):0]   COUNT,
  output logic                    ERR
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             err_reg, err_next;

  logic             pop_ok;
  logic             push_ok;
  logic [WIDTH-1:0] head_data;

  assign EMPTY = (count_reg == '0);
  assign FULL  = (count_reg == CNT_W'(DEPTH));
  assign COUNT = count_reg;
  assign ERR   = err_reg;

  // A full queue still accepts a push when the head leaves on the same edge.
  assign pop_ok  = POP & ~EMPTY;
  assign push_ok = PUSH & (~FULL | pop_ok);

  assign OUTPUT = pop_ok ? head_data : WIDTH'(BUS_IDLE);

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    err_next   = err_reg;

    if (pop_ok)  head_next = head_reg + 1'b1;
    if (push_ok) tail_next = tail_reg + 1'b1;

    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    if ((PUSH && !push_ok) || (POP && EMPTY)) err_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  fifo_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_ok),
    .wr_addr (tail_reg),
    .wr_data (VALUE),
    .rd_addr (head_reg),
    .rd_data (head_data)
  );

endmodule

// File: tb/tb_fifo_queue.sv
// Self-checking bench for fifo_queue: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_fifo_queue;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             PUSH;
  logic             POP;
  logic [WIDTH-1:0] VALUE;
  logic [WIDTH-1:0] OUTPUT;
  logic             FULL;
  logic             EMPTY;
  logic [4:0]       COUNT;
  logic             ERR;

  int checks;
  int errors;

  logic [7:0] model_q[$];
  bit         model_err;
  bit         seen_aa;

  fifo_queue #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .PUSH   (PUSH),
    .POP    (POP),
    .VALUE  (VALUE),
    .OUTPUT (OUTPUT),
    .FULL   (FULL),
    .EMPTY  (EMPTY),
    .COUNT  (COUNT),
    .ERR    (ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    int sz;
    sz = model_q.size();
    check({tag, ".COUNT"}, 32'(COUNT), 32'(sz));
    check({tag, ".EMPTY"}, 32'(EMPTY), 32'(sz == 0));
    check({tag, ".FULL"},  32'(FULL),  32'(sz == DEPTH));
    check({tag, ".ERR"},   32'(ERR),   32'(model_err));
  endtask

  // One clock cycle: drive, check at the falling edge, then advance the model.
  task automatic step(input string tag, input bit p, input bit q, input logic [7:0] v);
    int         sz;
    bit         pop_acc;
    bit         push_acc;
    logic [7:0] exp_out;
    PUSH  = p;
    POP   = q;
    VALUE = v;
    @(negedge clk);
    sz       = model_q.size();
    pop_acc  = q && (sz > 0);
    push_acc = p && ((sz < DEPTH) || pop_acc);
    exp_out  = pop_acc ? model_q[0] : 8'h00;
    if (OUTPUT == 8'hAA) seen_aa = 1'b1;
    check({tag, ".OUTPUT"}, 32'(OUTPUT), 32'(exp_out));
    check_status(tag);
    $display("txn %s push=%0b pop=%0b value=%02h out=%02h count=%0d err=%0b",
             tag, p, q, v, OUTPUT, COUNT, ERR);
    @(posedge clk);
    #1;
    if (pop_acc) void'(model_q.pop_front());
    if (push_acc) model_q.push_back(v);
    if ((p && !push_acc) || (q && sz == 0)) model_err = 1'b1;
    PUSH = 1'b0;
    POP  = 1'b0;
  endtask

  task automatic do_reset();
    PUSH = 1'b0;
    POP  = 1'b0;
    VALUE = '0;
    rst = 1'b0;
    model_q.delete();
    model_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    seen_aa   = 1'b0;
    rst       = 1'b1;
    PUSH      = 1'b0;
    POP       = 1'b0;
    VALUE     = '0;
    #2;

    // 1. reset then idle; entries present with POP low keep OUTPUT at 0
    do_reset();
    step("idle", 0, 0, 8'h00);
    step("idle_push", 1, 0, 8'h99);
    step("idle_hold", 0, 0, 8'h00);
    step("idle_pop", 0, 1, 8'h00);

    // 2. ordering
    step("ord_push", 1, 0, 8'h11);
    step("ord_push", 1, 0, 8'h22);
    step("ord_push", 1, 0, 8'h33);
    for (int i = 0; i < 3; i++) step("ord_pop", 0, 1, 8'h00);
    step("ord_end", 0, 0, 8'h00);

    // 3. fill and overflow
    for (int i = 0; i < 16; i++) step("fill", 1, 0, 8'(i));
    step("ovf", 1, 0, 8'hAA);
    step("ovf_chk", 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) step("drain", 0, 1, 8'h00);
    check("no_aa", 32'(seen_aa), 32'd0);

    // 4. underflow, then push+pop on empty (no fall-through)
    do_reset();
    step("udf", 0, 1, 8'h00);
    step("pp_empty", 1, 1, 8'h5A);
    step("pp_chk", 0, 0, 8'h00);
    step("pp_pop", 0, 1, 8'h00);

    // 5. wrap, then push+pop while full
    for (int i = 0; i < 16; i++) step("wfill", 1, 0, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 10; i++) step("wpop", 0, 1, 8'h00);
    for (int i = 0; i < 10; i++) step("wpush", 1, 0, 8'($urandom_range(0, 255)));
    step("full_pp", 1, 1, 8'h77);
    step("full_chk", 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) step("wdrain", 0, 1, 8'h00);

    // random traffic with phases biased toward filling and draining
    for (int i = 0; i < 400; i++) begin
      bit p;
      bit q;
      if ((i / 50) % 2 == 0) begin
        p = ($urandom_range(0, 99) < 70);
        q = ($urandom_range(0, 99) < 35);
      end else begin
        p = ($urandom_range(0, 99) < 35);
        q = ($urandom_range(0, 99) < 70);
      end
      step("rnd", p, q, 8'($urandom));
    end

    // 6. asynchronous reset between edges
    do_reset();
    step("ar_udf", 0, 1, 8'h00);
    for (int i = 0; i < 5; i++) step("ar_push", 1, 0, 8'(8'hC0 + i));
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    model_q.delete();
    model_err = 1'b0;
    check("ar_now.OUTPUT", 32'(OUTPUT), 32'd0);
    check_status("ar_now");
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("ar_pop", 0, 1, 8'h00);
    step("ar_end", 0, 0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
